// File: rtl/hsem_sched_pkg.sv
// Shared opcode, response-code and FSM-state encodings for the two-core
// hardware semaphore scheduler.
package hsem_sched_pkg;

   localparam logic OP_LOCK   = 1'b0;
   localparam logic OP_UNLOCK = 1'b1;

   localparam logic [1:0] RESP_OK     = 2'b00;
   localparam logic [1:0] RESP_BUSY   = 2'b01;
   localparam logic [1:0] RESP_ERR    = 2'b10;
   localparam logic [1:0] RESP_QUEUED = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/hsem_rr_arb.sv
// Two-way round-robin arbiter: ptr names the core that wins a tie.
module hsem_rr_arb (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (!ptr) begin
         if (req[0])      grant = 2'b01;
         else if (req[1]) grant = 2'b10;
      end else begin
         if (req[1])      grant = 2'b10;
         else if (req[0]) grant = 2'b01;
      end
   end

endmodule

// File: rtl/hsem_lock_sched.sv
// Two-core hardware semaphore table with a 3-cycle IDLE/SERVE/DONE service loop.
// Optional lock queueing with direct hand-off on unlock: define HSEM_SCHED_WAIT_EN.
module hsem_lock_sched
   import hsem_sched_pkg::*;
#(
   parameter int NSEM = 16,
   parameter int SW   = 4
) (
   input  logic            hclk,
   input  logic            hreset,
   input  logic [1:0]      req,
   input  logic [1:0]      op,
   input  logic [2*SW-1:0] sem,
   output logic [1:0]      ack,
   output logic [3:0]      resp,
   output logic [NSEM-1:0] lock_stat,
   output logic [NSEM-1:0] owner_stat,
   output logic [1:0]      wake,
   output logic [SW-1:0]   wake_sem
);

   state_e          state_q, state_d;
   logic            ptr_q, ptr_d;
   logic            core_q, core_d;
   logic            op_q, op_d;
   logic [SW-1:0]   sem_q, sem_d;
   logic [NSEM-1:0] lock_q, lock_d;
   logic [NSEM-1:0] owner_q, owner_d;
   logic [1:0]      ack_q, ack_d;
   logic [3:0]      resp_q, resp_d;
   logic [1:0]      grant;
   logic [1:0]      code;
   logic            held, is_own;
`ifdef HSEM_SCHED_WAIT_EN
   logic [NSEM-1:0] wait_q, wait_d;
   logic [1:0]      wake_q, wake_d;
   logic [SW-1:0]   wake_sem_q, wake_sem_d;
`endif

   hsem_rr_arb u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .grant (grant)
   );

   assign held   = lock_q[sem_q];
   assign is_own = (owner_q[sem_q] == core_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      core_d  = core_q;
      op_d    = op_q;
      sem_d   = sem_q;
      lock_d  = lock_q;
      owner_d = owner_q;
      ack_d   = 2'b00;
      resp_d  = 4'b0000;
      code    = RESP_OK;
`ifdef HSEM_SCHED_WAIT_EN
      wait_d     = wait_q;
      wake_d     = 2'b00;
      wake_sem_d = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               state_d = ST_SERVE;
               core_d  = grant[1];
               op_d    = grant[1] ? op[1] : op[0];
               sem_d   = grant[1] ? sem[SW +: SW] : sem[0 +: SW];
            end
         end
         ST_SERVE: begin
            state_d = ST_DONE;
            ptr_d   = ~core_q;
            case (op_q)
               OP_LOCK: begin
                  if (!held) begin
                     lock_d[sem_q]  = 1'b1;
                     owner_d[sem_q] = core_q;
                  end else if (!is_own) begin
`ifdef HSEM_SCHED_WAIT_EN
                     // Only one other core exists, so one bit fully names the waiter.
                     wait_d[sem_q] = 1'b1;
                     code          = RESP_QUEUED;
`else
                     code = RESP_BUSY;
`endif
                  end
               end
               default: begin
                  if (held && is_own) begin
`ifdef HSEM_SCHED_WAIT_EN
                     if (wait_q[sem_q]) begin
                        owner_d[sem_q] = ~core_q;
                        wait_d[sem_q]  = 1'b0;
                        wake_d[~core_q] = 1'b1;
                        wake_sem_d     = sem_q;
                     end else begin
                        lock_d[sem_q] = 1'b0;
                     end
`else
                     lock_d[sem_q] = 1'b0;
`endif
                  end else begin
                     code = RESP_ERR;
                  end
               end
            endcase
            ack_d[core_q]                = 1'b1;
            resp_d[{core_q, 1'b0} +: 2] = code;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         core_q  <= 1'b0;
         op_q    <= 1'b0;
         sem_q   <= '0;
         lock_q  <= '0;
         owner_q <= '0;
         ack_q   <= 2'b00;
         resp_q  <= 4'b0000;
`ifdef HSEM_SCHED_WAIT_EN
         wait_q     <= '0;
         wake_q     <= 2'b00;
         wake_sem_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         core_q  <= core_d;
         op_q    <= op_d;
         sem_q   <= sem_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         resp_q  <= resp_d;
`ifdef HSEM_SCHED_WAIT_EN
         wait_q     <= wait_d;
         wake_q     <= wake_d;
         wake_sem_q <= wake_sem_d;
`endif
      end
   end

   assign ack        = ack_q;
   assign resp       = resp_q;
   assign lock_stat  = lock_q;
   assign owner_stat = owner_q;
`ifdef HSEM_SCHED_WAIT_EN
   assign wake       = wake_q;
   assign wake_sem   = wake_sem_q;
`else
   assign wake       = 2'b00;
   assign wake_sem   = '0;
`endif

endmodule
